// File: rtl/aes128_iter_core_if.sv
// Valid/ready bundle for the iterative AES-128 core: one input channel
// (key + plaintext) and one output channel (ciphertext), plus busy status.
interface aes128_iter_core_if;
  logic [127:0] key_in;
  logic [127:0] data_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_out;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  modport master (
    output key_in, data_in, in_valid, out_ready,
    input  in_ready, data_out, out_valid, busy
  );

  modport slave (
    input  key_in, data_in, in_valid, out_ready,
    output in_ready, data_out, out_valid, busy
  );
endinterface

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryption core. UNROLL rounds are evaluated per clock
// with the round key expanded on the fly, so a block takes 10/UNROLL cycles.
// Byte 0 of every 128-bit word sits in bits [127:120].
module aes128_iter_core #(
  parameter int UNROLL = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  aes128_iter_core_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
      $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
    end
  endgenerate

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // The S-box is built at elaboration: multiplicative inverse (x^254, which
  // also maps 0 to 0) followed by the FIPS affine transform.
  function automatic logic [2047:0] gen_sbox_tbl();
    logic [2047:0] tbl;
    logic [7:0]    sq;
    logic [7:0]    inv;
    tbl = '0;
    for (int i = 0; i < 256; i++) begin
      sq  = 8'(i);
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
        sq  = gf_mul(sq, sq);
        inv = gf_mul(inv, sq);
      end
      tbl[8*i +: 8] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    return tbl;
  endfunction

  localparam logic [2047:0] SBOX_TBL = gen_sbox_tbl();

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = sbox(s[8*i +: 8]);
    end
    return r;
  endfunction

  // Byte (row r, column c) takes the byte from column (c + r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[8*(15-(4*c+w)) +: 8] = s[8*(15-(4*((c+w)%4)+w)) +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[32*(3-c) +: 32];
      r[32*(3-c) +: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction

  state_t       state_r, state_nx;
  logic [127:0] st_r, rk_r, data_out_r;
  logic [7:0]   rcon_r;
  logic [3:0]   rnd_r;
  logic         out_valid_r, busy_r;

  logic [127:0] st_nx_s, rk_nx_s;
  logic [7:0]   rcon_nx_s;
  logic [3:0]   rnd_nx_s;
  logic         last_s;
  logic         in_ready_s, accept_s;

  assign in_ready_s    = (state_r == IDLE) || ((state_r == DONE) && bus.out_ready);
  assign accept_s      = bus.in_valid && in_ready_s;
  assign bus.in_ready  = in_ready_s;
  assign bus.data_out  = data_out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;

  // Chain of UNROLL round stages; last_s flags that round 10 is in this cycle.
  always_comb begin : round_chain
    logic [31:0] tmp_v;
    logic [31:0] w0_v, w1_v, w2_v, w3_v;
    logic [127:0] sr_v;
    st_nx_s   = st_r;
    rk_nx_s   = rk_r;
    rcon_nx_s = rcon_r;
    rnd_nx_s  = rnd_r;
    last_s    = 1'b0;
    tmp_v     = 32'h0;
    w0_v      = 32'h0;
    w1_v      = 32'h0;
    w2_v      = 32'h0;
    w3_v      = 32'h0;
    sr_v      = '0;
    for (int j = 0; j < UNROLL; j++) begin
      tmp_v   = sub_word({rk_nx_s[23:0], rk_nx_s[31:24]}) ^ {rcon_nx_s, 24'h000000};
      w0_v    = rk_nx_s[127:96] ^ tmp_v;
      w1_v    = rk_nx_s[95:64] ^ w0_v;
      w2_v    = rk_nx_s[63:32] ^ w1_v;
      w3_v    = rk_nx_s[31:0] ^ w2_v;
      rk_nx_s = {w0_v, w1_v, w2_v, w3_v};
      sr_v    = shift_rows(sub_bytes(st_nx_s));
      if (rnd_nx_s == 4'd10) begin
        st_nx_s = sr_v ^ rk_nx_s;
        last_s  = 1'b1;
      end else begin
        st_nx_s = mix_columns(sr_v) ^ rk_nx_s;
      end
      rcon_nx_s = xtime(rcon_nx_s);
      rnd_nx_s  = rnd_nx_s + 4'd1;
    end
  end

  // Next-state logic for the IDLE / ROUND / DONE controller.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nx = ROUND;
        else          state_nx = IDLE;
      end
      ROUND: begin
        if (last_s) state_nx = DONE;
        else        state_nx = ROUND;
      end
      DONE: begin
        if (accept_s)          state_nx = ROUND;
        else if (bus.out_ready) state_nx = IDLE;
        else                   state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_r <= IDLE;
    else        state_r <= state_nx;
  end

  // Round state, key, rcon and counter; loaded on accept, stepped in ROUND.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_r   <= '0;
      rk_r   <= '0;
      rcon_r <= 8'h00;
      rnd_r  <= 4'd0;
    end else if (accept_s) begin
      st_r   <= bus.data_in ^ bus.key_in;
      rk_r   <= bus.key_in;
      rcon_r <= 8'h01;
      rnd_r  <= 4'd1;
    end else if (state_r == ROUND) begin
      st_r   <= st_nx_s;
      rk_r   <= rk_nx_s;
      rcon_r <= rcon_nx_s;
      rnd_r  <= rnd_nx_s;
    end
  end

  // Registered outputs: ciphertext captured on completion, flags follow state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_out_r  <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if ((state_r == ROUND) && last_s) data_out_r <= st_nx_s;
      out_valid_r <= (state_nx == DONE);
      busy_r      <= (state_nx == ROUND);
    end
  end

endmodule

// File: tb/tb_aes128_iter_core.sv
// Directed bench for aes128_iter_core: FIPS-197 vectors at every UNROLL,
// latency/busy timing, backpressure, back-to-back, mid-block reset and
// ignored inputs during ROUND.
module tb_aes128_iter_core;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         CLK;
  logic         RST_N;
  logic [127:0] key_v, data_v;
  logic         in_valid_v, out_ready_v;
  int           compared_cnt = 0;
  int           mismatched_cnt = 0;

  aes128_iter_core_if bus1();
  aes128_iter_core_if bus2();
  aes128_iter_core_if bus5();
  aes128_iter_core_if bus10();

  assign bus1.key_in     = key_v;
  assign bus1.data_in    = data_v;
  assign bus1.in_valid   = in_valid_v;
  assign bus1.out_ready  = out_ready_v;
  assign bus2.key_in     = key_v;
  assign bus2.data_in    = data_v;
  assign bus2.in_valid   = in_valid_v;
  assign bus2.out_ready  = out_ready_v;
  assign bus5.key_in     = key_v;
  assign bus5.data_in    = data_v;
  assign bus5.in_valid   = in_valid_v;
  assign bus5.out_ready  = out_ready_v;
  assign bus10.key_in    = key_v;
  assign bus10.data_in   = data_v;
  assign bus10.in_valid  = in_valid_v;
  assign bus10.out_ready = out_ready_v;

  aes128_iter_core #(.UNROLL(1))  dut1  (.CLK(CLK), .RST_N(RST_N), .bus(bus1));
  aes128_iter_core #(.UNROLL(2))  dut2  (.CLK(CLK), .RST_N(RST_N), .bus(bus2));
  aes128_iter_core #(.UNROLL(5))  dut5  (.CLK(CLK), .RST_N(RST_N), .bus(bus5));
  aes128_iter_core #(.UNROLL(10)) dut10 (.CLK(CLK), .RST_N(RST_N), .bus(bus10));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    compared_cnt++;
    if (got !== exp) begin
      mismatched_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One block through the UNROLL=1 core; optionally scrambles inputs during ROUND.
  task automatic run_block(input logic [127:0] k, input logic [127:0] p, input bit noisy,
                           output logic [127:0] ct, output int lat, output int busy_n);
    key_v = k;
    data_v = p;
    in_valid_v = 1'b1;
    @(posedge CLK); #1;
    in_valid_v = 1'b0;
    lat = 0;
    ct = '0;
    busy_n = bus1.busy ? 1 : 0;
    for (int n = 1; n <= 30; n++) begin
      if (noisy && n < 5) begin
        in_valid_v = (n % 2 == 1);
        key_v  = {$urandom, $urandom, $urandom, $urandom};
        data_v = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        in_valid_v = 1'b0;
      end
      @(posedge CLK); #1;
      if (bus1.busy) busy_n++;
      if (bus1.out_valid) begin
        lat = n;
        ct = bus1.data_out;
        break;
      end
    end
  endtask

  initial begin
    logic [127:0] ct;
    int lat, busy_n;
    int lat_u [4];
    logic [127:0] ct_u [4];
    int n_acc, n_out, done_acc, last_acc, vec, ov_seen;
    logic pre_rdy, pre_dv;

    RST_N = 1'b0;
    in_valid_v = 1'b0;
    out_ready_v = 1'b1;
    key_v = '0;
    data_v = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_out_valid", 160'(bus1.out_valid), 160'(1'b0));
    check_eq("rst_data_out",  160'(bus1.data_out),  160'(128'h0));
    check_eq("rst_busy",      160'(bus1.busy),      160'(1'b0));
    check_eq("rst_in_ready",  160'(bus1.in_ready),  160'(1'b1));
    check_eq("rst_in_ready_u10", 160'(bus10.in_ready), 160'(1'b1));
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check_eq("post_rst_in_ready", 160'(bus1.in_ready), 160'(1'b1));

    // FIPS-197 App. B on all four cores at once.
    for (int i = 0; i < 4; i++) begin
      lat_u[i] = 0;
      ct_u[i] = '0;
    end
    key_v = KEY_B;
    data_v = PT_B;
    in_valid_v = 1'b1;
    @(posedge CLK); #1;
    in_valid_v = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      @(posedge CLK); #1;
      if (bus1.out_valid && lat_u[0] == 0)  begin lat_u[0] = n; ct_u[0] = bus1.data_out;  end
      if (bus2.out_valid && lat_u[1] == 0)  begin lat_u[1] = n; ct_u[1] = bus2.data_out;  end
      if (bus5.out_valid && lat_u[2] == 0)  begin lat_u[2] = n; ct_u[2] = bus5.data_out;  end
      if (bus10.out_valid && lat_u[3] == 0) begin lat_u[3] = n; ct_u[3] = bus10.data_out; end
    end
    check_eq("b_ct_u1",   160'(ct_u[0]), 160'(CT_B));
    check_eq("b_ct_u2",   160'(ct_u[1]), 160'(CT_B));
    check_eq("b_ct_u5",   160'(ct_u[2]), 160'(CT_B));
    check_eq("b_ct_u10",  160'(ct_u[3]), 160'(CT_B));
    check_eq("b_lat_u1",  160'(lat_u[0]), 160'(10));
    check_eq("b_lat_u2",  160'(lat_u[1]), 160'(5));
    check_eq("b_lat_u5",  160'(lat_u[2]), 160'(2));
    check_eq("b_lat_u10", 160'(lat_u[3]), 160'(1));

    // FIPS-197 App. C.1 with latency and busy window.
    run_block(KEY_C1, PT_C1, 1'b0, ct, lat, busy_n);
    check_eq("c1_ct",   160'(ct), 160'(CT_C1));
    check_eq("c1_lat",  160'(lat), 160'(10));
    check_eq("c1_busy", 160'(busy_n), 160'(10));

    // Backpressure: hold out_ready low for 5 cycles after completion.
    @(posedge CLK); #1;
    out_ready_v = 1'b0;
    run_block(KEY_B, PT_B, 1'b0, ct, lat, busy_n);
    check_eq("bp_lat", 160'(lat), 160'(10));
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(posedge CLK); #1;
      end
      check_eq("bp_out_valid", 160'(bus1.out_valid), 160'(1'b1));
      check_eq("bp_data_out",  160'(bus1.data_out),  160'(CT_B));
      check_eq("bp_in_ready",  160'(bus1.in_ready),  160'(1'b0));
    end
    out_ready_v = 1'b1;
    #1;
    check_eq("bp_release_in_ready", 160'(bus1.in_ready), 160'(1'b1));
    @(posedge CLK); #1;
    check_eq("bp_drop_out_valid", 160'(bus1.out_valid), 160'(1'b0));
    check_eq("bp_keep_data_out",  160'(bus1.data_out),  160'(CT_B));

    // Back-to-back with alternating C.1 / B vectors and out_ready high.
    n_acc = 0; n_out = 0; done_acc = 0; last_acc = 0; vec = 0;
    key_v = KEY_C1;
    data_v = PT_C1;
    in_valid_v = 1'b1;
    for (int cyc = 1; cyc <= 60 && n_out < 3; cyc++) begin
      pre_rdy = bus1.in_ready;
      pre_dv = bus1.out_valid;
      @(posedge CLK); #1;
      if (bus1.out_valid) begin
        check_eq("b2b_ct", 160'(bus1.data_out), 160'((n_out % 2 == 0) ? CT_C1 : CT_B));
        n_out++;
      end
      if (pre_rdy) begin
        if (n_acc > 0) check_eq("b2b_gap", 160'(cyc - last_acc), 160'(11));
        if (pre_dv) done_acc++;
        last_acc = cyc;
        n_acc++;
        vec = 1 - vec;
        key_v  = (vec == 1) ? KEY_B : KEY_C1;
        data_v = (vec == 1) ? PT_B : PT_C1;
      end
      if (n_out == 3) in_valid_v = 1'b0;
    end
    in_valid_v = 1'b0;
    check_eq("b2b_outputs",    160'(n_out), 160'(3));
    check_eq("b2b_accepts",    160'(n_acc), 160'(3));
    check_eq("b2b_done_accept", 160'(done_acc), 160'(2));

    // Reset during round 4 of a block.
    @(posedge CLK); #1;
    key_v = KEY_C1;
    data_v = PT_C1;
    in_valid_v = 1'b1;
    @(posedge CLK); #1;
    in_valid_v = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 160'(bus1.out_valid), 160'(1'b0));
    check_eq("mid_rst_data_out",  160'(bus1.data_out),  160'(128'h0));
    check_eq("mid_rst_in_ready",  160'(bus1.in_ready),  160'(1'b1));
    check_eq("mid_rst_busy",      160'(bus1.busy),      160'(1'b0));
    @(posedge CLK); #1;
    RST_N = 1'b1;
    ov_seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge CLK); #1;
      if (bus1.out_valid) ov_seen++;
    end
    check_eq("mid_rst_no_output", 160'(ov_seen), 160'(0));
    run_block(KEY_C1, PT_C1, 1'b0, ct, lat, busy_n);
    check_eq("after_rst_ct",  160'(ct), 160'(CT_C1));
    check_eq("after_rst_lat", 160'(lat), 160'(10));

    // Input activity during ROUND must not disturb the in-flight block.
    @(posedge CLK); #1;
    run_block(KEY_B, PT_B, 1'b1, ct, lat, busy_n);
    check_eq("noisy_ct",  160'(ct), 160'(CT_B));
    check_eq("noisy_lat", 160'(lat), 160'(10));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatched_cnt);
    $finish;
  end
endmodule
